// File: rtl/alarm_sequencer.sv
// rtl/alarm_sequencer.sv - alarm ring/snooze/timeout sequencer
//
// Purpose: starts ringing when the time of day matches the armed alarm time.
// The user can snooze a limited number of times or stop the alarm. Unanswered
// ringing stops by itself after a timeout.
//
// Optional feature: define ALARM_BEEP_EN to pulse sound_alarm at 1 s on / 1 s off
// while ringing. Without it, sound_alarm is steady while ringing.
//
// Ports:
//   clk              system clock, rising edge
//   reset            asynchronous active-low reset
//   one_second       1-cycle pulse per second (beep cadence, ALARM_BEEP_EN only)
//   one_minute       1-cycle pulse per minute (ring timeout, snooze countdown)
//   do_snooze        1-cycle pulse, snooze button
//   stop_alarm       1-cycle pulse, alarm-off button
//   load_alarm       1-cycle pulse, new alarm time loaded (forces IDLE)
//   alarm_enable     level, alarm armed when 1 (0 forces IDLE)
//   current_time     BCD HH:MM time of day
//   alarm_time       BCD HH:MM alarm setting
//   sound_alarm      registered alarm drive
//   snoozing         registered, 1 while in SNOOZE
//   snooze_remaining registered, minutes left in the current snooze (0 elsewhere)
//   state_out        registered state code: IDLE=0 RINGING=1 SNOOZE=2 DONE=3
module alarm_sequencer #(
  parameter int SNOOZE_MIN       = 9,
  parameter int RING_TIMEOUT_MIN = 5,
  parameter int MAX_SNOOZES      = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        one_second,
  input  logic        one_minute,
  input  logic        do_snooze,
  input  logic        stop_alarm,
  input  logic        load_alarm,
  input  logic        alarm_enable,
  input  logic [15:0] current_time,
  input  logic [15:0] alarm_time,
  output logic        sound_alarm,
  output logic        snoozing,
  output logic [3:0]  snooze_remaining,
  output logic [1:0]  state_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [3:0] SNOOZE_LOAD  = 4'(SNOOZE_MIN);
  localparam logic [3:0] RING_LIMIT   = 4'(RING_TIMEOUT_MIN);
  localparam logic [2:0] SNOOZE_LIMIT = 3'(MAX_SNOOZES);

  state_t     state, state_nxt;
  logic [3:0] ring_cnt, ring_nxt;
  logic [2:0] snooze_cnt, snooze_nxt;
  logic [3:0] rem_nxt;
  logic       beep, beep_nxt;
  logic       beep_tick;
  logic       match;

  assign match = (current_time == alarm_time);

`ifdef ALARM_BEEP_EN
  assign beep_tick = one_second;
`else
  // Beep cadence is not built; the second tick is intentionally ignored.
  logic unused_one_second;
  assign unused_one_second = one_second;
  assign beep_tick = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    ring_nxt   = ring_cnt;
    snooze_nxt = snooze_cnt;
    rem_nxt    = snooze_remaining;
    beep_nxt   = beep;

    if (!alarm_enable || load_alarm) begin
      // Disarm or reload overrides everything and wipes the alarm event.
      state_nxt  = IDLE;
      ring_nxt   = '0;
      snooze_nxt = '0;
      rem_nxt    = '0;
      beep_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (match) begin
            state_nxt  = RINGING;
            ring_nxt   = '0;
            snooze_nxt = '0;
            beep_nxt   = 1'b0;
          end
        end
        RINGING: begin
          if (stop_alarm) begin
            state_nxt = DONE;
          end else if (do_snooze && (snooze_cnt < SNOOZE_LIMIT)) begin
            // A minute tick in this same cycle is not counted against the snooze.
            state_nxt  = SNOOZE;
            snooze_nxt = snooze_cnt + 3'd1;
            rem_nxt    = SNOOZE_LOAD;
          end else begin
            if (beep_tick) begin
              beep_nxt = ~beep;
            end
            if (one_minute) begin
              ring_nxt = ring_cnt + 4'd1;
              if (ring_nxt == RING_LIMIT) begin
                state_nxt = DONE;
              end
            end
          end
        end
        SNOOZE: begin
          if (stop_alarm) begin
            state_nxt = DONE;
            rem_nxt   = '0;
          end else if (one_minute) begin
            rem_nxt = snooze_remaining - 4'd1;
            if (rem_nxt == 4'd0) begin
              // Back to ringing with a fresh timeout; snooze count is kept.
              state_nxt = RINGING;
              ring_nxt  = '0;
              beep_nxt  = 1'b0;
            end
          end
        end
        DONE: begin
          // Wait for the alarm minute to pass so it cannot re-trigger.
          if (!match) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      ring_cnt         <= '0;
      snooze_cnt       <= '0;
      snooze_remaining <= '0;
      beep             <= 1'b0;
      sound_alarm      <= 1'b0;
      snoozing         <= 1'b0;
    end else begin
      state            <= state_nxt;
      ring_cnt         <= ring_nxt;
      snooze_cnt       <= snooze_nxt;
      snooze_remaining <= rem_nxt;
      beep             <= beep_nxt;
`ifdef ALARM_BEEP_EN
      sound_alarm      <= (state_nxt == RINGING) && beep_nxt;
`else
      sound_alarm      <= (state_nxt == RINGING);
`endif
      snoozing         <= (state_nxt == SNOOZE);
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb/tb_alarm_sequencer.sv - directed and randomized checks of alarm_sequencer
module tb_alarm_sequencer;

  localparam int SNOOZE_MIN       = 9;
  localparam int RING_TIMEOUT_MIN = 5;
  localparam int MAX_SNOOZES      = 3;

  localparam int M_IDLE = 0, M_RING = 1, M_SNOOZE = 2, M_DONE = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        one_second = 1'b0;
  logic        one_minute = 1'b0;
  logic        do_snooze = 1'b0;
  logic        stop_alarm = 1'b0;
  logic        load_alarm = 1'b0;
  logic        alarm_enable = 1'b0;
  logic [15:0] current_time = 16'h0000;
  logic [15:0] alarm_time = 16'h0000;
  logic        sound_alarm;
  logic        snoozing;
  logic [3:0]  snooze_remaining;
  logic [1:0]  state_out;

  int checks = 0;
  int errors = 0;

  // Reference model: alarm event described by mode, minutes rung, snoozes
  // used, minutes left in the snooze and the beep phase.
  int m_mode = M_IDLE;
  int m_rung = 0;
  int m_snoozes_used = 0;
  int m_left = 0;
  int m_phase = 0;

  alarm_sequencer #(
    .SNOOZE_MIN(SNOOZE_MIN),
    .RING_TIMEOUT_MIN(RING_TIMEOUT_MIN),
    .MAX_SNOOZES(MAX_SNOOZES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .one_second(one_second),
    .one_minute(one_minute),
    .do_snooze(do_snooze),
    .stop_alarm(stop_alarm),
    .load_alarm(load_alarm),
    .alarm_enable(alarm_enable),
    .current_time(current_time),
    .alarm_time(alarm_time),
    .sound_alarm(sound_alarm),
    .snoozing(snoozing),
    .snooze_remaining(snooze_remaining),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_mode = M_IDLE;
    m_rung = 0;
    m_snoozes_used = 0;
    m_left = 0;
    m_phase = 0;
  endtask

  task automatic start_ringing();
    m_mode = M_RING;
    m_rung = 0;
    m_phase = 0;
  endtask

  // One clock of the alarm rules applied to the inputs seen at the edge.
  task automatic model_step();
    if (alarm_enable == 1'b0 || load_alarm == 1'b1) begin
      model_clear();
      return;
    end
    if (m_mode == M_IDLE) begin
      if (current_time == alarm_time) begin
        start_ringing();
        m_snoozes_used = 0;
      end
    end else if (m_mode == M_RING) begin
      if (stop_alarm) m_mode = M_DONE;
      else if (do_snooze && m_snoozes_used < MAX_SNOOZES) begin
        m_mode = M_SNOOZE;
        m_snoozes_used += 1;
        m_left = SNOOZE_MIN;
      end else begin
        if (one_second) m_phase = 1 - m_phase;
        if (one_minute) m_rung += 1;
        if (m_rung >= RING_TIMEOUT_MIN) m_mode = M_DONE;
      end
    end else if (m_mode == M_SNOOZE) begin
      if (stop_alarm) m_mode = M_DONE;
      else if (one_minute) begin
        m_left -= 1;
        if (m_left == 0) start_ringing();
      end
    end else begin
      if (current_time != alarm_time) m_mode = M_IDLE;
    end
  endtask

  function automatic logic [7:0] model_outputs();
    logic snd;
`ifdef ALARM_BEEP_EN
    snd = (m_mode == M_RING) && (m_phase == 1);
`else
    snd = (m_mode == M_RING);
`endif
    return {2'(m_mode), snd, (m_mode == M_SNOOZE), (m_mode == M_SNOOZE) ? 4'(m_left) : 4'd0};
  endfunction

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    model_step();
    one_second = 1'b0;
    one_minute = 1'b0;
    do_snooze  = 1'b0;
    stop_alarm = 1'b0;
    load_alarm = 1'b0;
    check(tag, {24'd0, state_out, sound_alarm, snoozing, snooze_remaining}, {24'd0, model_outputs()});
  endtask

  task automatic minutes(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      one_minute = 1'b1;
      tick(tag);
    end
  endtask

  logic exp_ring_sound;

  initial begin
`ifdef ALARM_BEEP_EN
    exp_ring_sound = 1'b0;
`else
    exp_ring_sound = 1'b1;
`endif
    // Reset state
    #2;
    check("reset_outputs", {26'd0, state_out, sound_alarm, snoozing, snooze_remaining}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Alarm trigger at 07:00
    alarm_enable = 1'b1;
    alarm_time   = 16'h0700;
    current_time = 16'h0659;
    tick("pre_match");
    check("pre_match_state", state_out, 0);
    current_time = 16'h0700;
    tick("match");
    check("trigger_state", state_out, 1);
    check("trigger_sound", sound_alarm, exp_ring_sound);
    current_time = 16'h0701;

    // Snooze and count down
    do_snooze = 1'b1;
    tick("snooze1");
    check("snooze1_flag", snoozing, 1);
    check("snooze1_rem", snooze_remaining, 9);
    minutes(8, "snooze1_count");
    check("snooze1_rem_1", snooze_remaining, 1);
    minutes(1, "snooze1_end");
    check("snooze1_back_ring", state_out, 1);
    check("snooze1_rem_0", snooze_remaining, 0);

    // Snoozes two and three, then the fourth is refused
    for (int s = 0; s < 2; s++) begin
      do_snooze = 1'b1;
      tick("snooze_n");
      check("snooze_n_state", state_out, 2);
      minutes(SNOOZE_MIN, "snooze_n_count");
    end
    do_snooze = 1'b1;
    tick("snooze4");
    check("snooze4_ignored", state_out, 1);
    check("snooze4_sound", sound_alarm, exp_ring_sound);
    minutes(4, "timeout_count");
    check("timeout_not_yet", state_out, 1);
    minutes(1, "timeout");
    check("timeout_done", state_out, 3);
    check("timeout_silent", sound_alarm, 0);
    tick("done_to_idle");
    check("done_to_idle_state", state_out, 0);

    // Same-cycle snooze and stop, no re-trigger in the alarm minute
    current_time = 16'h0700;
    tick("retrigger");
    check("retrigger_state", state_out, 1);
    do_snooze  = 1'b1;
    stop_alarm = 1'b1;
    tick("stop_wins");
    check("stop_wins_state", state_out, 3);
    tick("hold_match_1");
    tick("hold_match_2");
    check("hold_match_done", state_out, 3);
    current_time = 16'h0701;
    tick("leave_minute");
    check("leave_minute_idle", state_out, 0);
    tick("no_retrigger");
    check("no_retrigger_idle", state_out, 0);

    // Disarm while snoozing
    current_time = 16'h0700;
    tick("ring_again");
    do_snooze = 1'b1;
    tick("snooze_again");
    alarm_enable = 1'b0;
    tick("disarm");
    check("disarm_outputs", {26'd0, state_out, sound_alarm, snoozing, snooze_remaining}, 32'd0);
    alarm_enable = 1'b1;
    tick("rearm");
    check("rearm_ring", state_out, 1);

`ifdef ALARM_BEEP_EN
    for (int b = 0; b < 4; b++) begin
      one_second = 1'b1;
      tick("beep");
      check("beep_phase", sound_alarm, (b % 2 == 0) ? 1 : 0);
    end
`endif

    // Asynchronous reset mid-ringing
    reset = 1'b0;
    #1;
    check("async_reset", {26'd0, state_out, sound_alarm, snoozing, snooze_remaining}, 32'd0);
    model_clear();
    #1;
    reset = 1'b1;
    current_time = 16'h0701;
    tick("post_reset");

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      one_second   = ($urandom_range(3) == 0);
      one_minute   = ($urandom_range(5) == 0);
      do_snooze    = ($urandom_range(9) == 0);
      stop_alarm   = ($urandom_range(24) == 0);
      alarm_enable = ($urandom_range(99) != 0);
      if ($urandom_range(199) == 0) begin
        load_alarm = 1'b1;
        alarm_time = 16'($urandom_range(16'h2359));
      end
      if ($urandom_range(3) == 0) begin
        current_time = ($urandom_range(1) == 0) ? alarm_time : 16'($urandom_range(16'h2359));
      end
      tick("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_sequencer.md
ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

Interface
REQ-001 Parameter SNOOZE_MIN, default 9, minutes per snooze period (range 1-15).
REQ-002 Parameter RING_TIMEOUT_MIN, default 5, minutes of unanswered ringing before auto-stop (range 1-15).
REQ-003 Parameter MAX_SNOOZES, default 3, snoozes allowed per alarm event (range 0-7).
REQ-004 clk  input  1  system clock (MCLK domain); all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 one_second  input  1  one-cycle pulse, once per second.
REQ-007 one_minute  input  1  one-cycle pulse, once per minute.
REQ-008 do_snooze  input  1  one-cycle pulse, snooze button.
REQ-009 stop_alarm  input  1  one-cycle pulse, alarm-off button.
REQ-010 load_alarm  input  1  one-cycle pulse, new alarm time loaded.
REQ-011 alarm_enable  input  1  level, alarm armed when 1.
REQ-012 current_time  input  16  BCD HH:MM time of day.
REQ-013 alarm_time  input  16  BCD HH:MM alarm setting.
REQ-014 sound_alarm  output  1  registered alarm drive.
REQ-015 snoozing  output  1  registered, 1 while in SNOOZE.
REQ-016 snooze_remaining  output  4  registered, minutes left in current snooze.
REQ-017 state_out  output  2  registered state code for debug.

Function
REQ-018 States, encoded on state_out: IDLE=0, RINGING=1, SNOOZE=2, DONE=3.
REQ-019 match = (current_time == alarm_time), full 16-bit compare.
REQ-020 IDLE -> RINGING when match && alarm_enable; ring counter and snooze counter cleared on entry.
REQ-021 RINGING: ring counter +1 on each one_minute pulse; at RING_TIMEOUT_MIN -> DONE.
REQ-022 RINGING, stop_alarm -> DONE.
REQ-023 RINGING, do_snooze with snooze counter < MAX_SNOOZES -> SNOOZE; snooze counter +1; snooze_remaining loads SNOOZE_MIN.
REQ-024 RINGING, do_snooze with snooze counter == MAX_SNOOZES: ignored, stay RINGING.
REQ-025 Same-cycle stop_alarm and do_snooze: stop_alarm wins.
REQ-026 SNOOZE: snooze_remaining -1 on each one_minute; when decrement reaches 0 -> RINGING, ring counter cleared, snooze counter retained.
REQ-027 SNOOZE, stop_alarm -> DONE; do_snooze ignored.
REQ-028 DONE -> IDLE on the first cycle match == 0 (no re-trigger within the alarm minute).
REQ-029 alarm_enable == 0 or load_alarm == 1 in any state -> IDLE next cycle, all counters cleared; priority above every other transition.
REQ-030 sound_alarm = 1 exactly while state == RINGING (subject to REQ-035); snoozing = 1 exactly while state == SNOOZE.
REQ-031 snooze_remaining = 0 outside SNOOZE.
REQ-032 All outputs registered; transitions and outputs update one clk after the causing input cycle.
REQ-033 one_minute arriving in the same cycle as a state entry does not count toward the new state.

Reset
REQ-034 reset low asynchronously forces state IDLE, sound_alarm 0, snoozing 0, snooze_remaining 0, state_out 0, all internal counters 0, beep phase 0; operation resumes on the first clk edge after reset goes high.

Configuration
REQ-035 Macro ALARM_BEEP_EN: when defined, a beep-phase bit toggles on each one_second while RINGING (cleared on entry), and sound_alarm = RINGING && beep phase (1 s on / 1 s off, starting off). When undefined, sound_alarm is steady 1 while RINGING and one_second is unused.

Verification
REQ-036 alarm_enable=1, alarm_time=16'h0700, current_time 0659 -> 0700 -> state RINGING and sound_alarm=1 one clk later.
REQ-037 RINGING, do_snooze -> snoozing=1, snooze_remaining=9; nine one_minute pulses -> RINGING again, snooze_remaining=0.
REQ-038 Four ring/snooze cycles with MAX_SNOOZES=3 -> fourth do_snooze ignored, sound_alarm stays 1; five one_minute pulses -> DONE, sound_alarm=0.
REQ-039 Same-cycle do_snooze + stop_alarm in RINGING -> DONE; current_time held at 0700 stays DONE; current_time 0701 -> IDLE, no re-trigger.
REQ-040 alarm_enable dropped in SNOOZE, and reset asserted mid-RINGING -> IDLE with all outputs 0 (reset: immediately, without a clk edge).
REQ-041 ALARM_BEEP_EN defined, RINGING, four one_second pulses -> sound_alarm 1,0,1,0 after each successive pulse.
